memory_interface: RTL and testbench

- Sits directly downstream of the CPU control unit, between its mem_read/mem_write strobes and the main RAM.
- Latches the address from MAR and the write data from MDR, then runs a multi-cycle access against a synchronous single-port RAM.
- Returns read data to the MDR input mux.
- Completes each transfer with a four-phase done handshake, so the control FSM can hold a fetch/load/store state until the memory finishes.

---
 rtl/memory_interface_if.sv | 32 +++
 rtl/memory_interface.sv | 132 +++++++++++++
 tb/tb_memory_interface.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/memory_interface_if.sv
// CPU-side request/response signals and RAM-side port of the memory interface.
// slave: the memory_interface block; master: its environment (control unit and RAM).
interface memory_interface_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 32
);
   logic              mem_read;
   logic              mem_write;
   logic [31:0]       mar_q;
   logic [DATA_W-1:0] mdr_q;
   logic [DATA_W-1:0] mem_data_out;
   logic              mem_done;
   logic              mem_busy;
   logic              mem_err;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic              ram_re;
   logic              ram_we;
   logic [DATA_W-1:0] ram_rdata;

   modport slave (
      input  mem_read, mem_write, mar_q, mdr_q, ram_rdata,
      output mem_data_out, mem_done, mem_busy, mem_err,
             ram_addr, ram_wdata, ram_re, ram_we
   );

   modport master (
      output mem_read, mem_write, mar_q, mdr_q, ram_rdata,
      input  mem_data_out, mem_done, mem_busy, mem_err,
             ram_addr, ram_wdata, ram_re, ram_we
   );
endinterface

// File: rtl/memory_interface.sv
// Multi-cycle bridge from CPU mem_read/mem_write strobes to a synchronous single-port RAM.
// Optional MEM_ADDR_CHECK_EN: flag addresses beyond the RAM depth instead of wrapping.
module memory_interface #(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input logic               clock,
   input logic               reset,
   memory_interface_if.slave bus
);
   localparam int unsigned CNT_W = 4;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_WAIT       = 3'd1;
   localparam logic [2:0] ST_RD_ISSUE   = 3'd2;
   localparam logic [2:0] ST_RD_CAPTURE = 3'd3;
   localparam logic [2:0] ST_WR_ISSUE   = 3'd4;
   localparam logic [2:0] ST_DONE       = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              op_wr_q, op_wr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              err_q, err_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              re_q, re_d;
   logic              we_q, we_d;
   logic              addr_bad;

`ifdef MEM_ADDR_CHECK_EN
   assign addr_bad = (bus.mar_q >> ADDR_W) != 32'd0;
`else
   // Upper address bits are deliberately ignored; the address wraps.
   logic addr_unused;
   assign addr_bad    = 1'b0;
   assign addr_unused = ^(bus.mar_q >> ADDR_W);
`endif

   // State and registered outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_wr_q <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         re_q    <= 1'b0;
         we_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_wr_q <= op_wr_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         re_q    <= re_d;
         we_q    <= we_d;
      end
   end

   // Next state; outputs are decoded from the next state so they register with it
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_wr_d = op_wr_q;
      data_d  = data_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.mem_read && bus.mem_write) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else if (bus.mem_read || bus.mem_write) begin
               if (addr_bad) begin
                  err_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  addr_d  = bus.mar_q[ADDR_W-1:0];
                  wdata_d = bus.mdr_q;
                  op_wr_d = bus.mem_write;
                  cnt_d   = CNT_W'(WAIT_CYCLES);
                  err_d   = 1'b0;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
            else             state_d = op_wr_q ? ST_WR_ISSUE : ST_RD_ISSUE;
         end
         ST_RD_ISSUE:   state_d = ST_RD_CAPTURE;
         ST_RD_CAPTURE: begin
            data_d  = bus.ram_rdata;
            state_d = ST_DONE;
         end
         ST_WR_ISSUE:   state_d = ST_DONE;
         ST_DONE: begin
            if (!bus.mem_read && !bus.mem_write) state_d = ST_IDLE;
         end
         default:       state_d = ST_IDLE;
      endcase

      re_d   = (state_d == ST_RD_ISSUE);
      we_d   = (state_d == ST_WR_ISSUE);
      done_d = (state_d == ST_DONE);
      busy_d = (state_d == ST_WAIT) || (state_d == ST_RD_ISSUE) ||
               (state_d == ST_RD_CAPTURE) || (state_d == ST_WR_ISSUE);
   end

   assign bus.mem_data_out = data_q;
   assign bus.mem_done     = done_q;
   assign bus.mem_busy     = busy_q;
   assign bus.mem_err      = err_q;
   assign bus.ram_addr     = addr_q;
   assign bus.ram_wdata    = wdata_q;
   assign bus.ram_re       = re_q;
   assign bus.ram_we       = we_q;
endmodule

// File: tb/tb_memory_interface.sv
// Directed bench for memory_interface: RAM model, shadow-memory scoreboard, latency and pulse checks.
module tb_memory_interface;
   localparam int unsigned ADDR_W      = 9;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned WAIT_CYCLES = 2;
`ifdef MEM_ADDR_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   memory_interface_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   memory_interface #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)
   ) dut (
      .clock(clk),
      .reset(rst_n),
      .bus  (bus)
   );

   // Synchronous single-port RAM with a bench backdoor write port
   logic [DATA_W-1:0] ram [2**ADDR_W];
   logic              bd_we;
   logic [ADDR_W-1:0] bd_addr;
   logic [DATA_W-1:0] bd_data;
   always @(posedge clk) begin
      if (bd_we)           ram[bd_addr]      <= bd_data;
      else if (bus.ram_we) ram[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re)      bus.ram_rdata     <= ram[bus.ram_addr];
   end

   logic [DATA_W-1:0] shadow [2**ADDR_W];
   logic [DATA_W-1:0] exp_q [$];
   logic [DATA_W-1:0] last_dout;
   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic preload(input int a, input logic [DATA_W-1:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = ADDR_W'(a); bd_data = d;
      @(negedge clk);
      bd_we = 1'b0;
      shadow[a] = d;
   endtask

   // Drive one request from a negedge; expectations come from the shadow model
   task automatic access(input string tag, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [DATA_W-1:0] wd, input bit hold);
      bit bad, err_exp;
      int lat_exp, re_exp, we_exp, lat, re_n, we_n, pulse_k, extra;
      logic [ADDR_W-1:0] a, pulse_addr;
      logic [DATA_W-1:0] pulse_wd;
      a       = addr[ADDR_W-1:0];
      bad     = CHK && ((addr >> ADDR_W) != 32'd0);
      err_exp = (rd && wr) || bad;
      if (err_exp) begin
         lat_exp = 0; re_exp = 0; we_exp = 0;
      end else if (rd) begin
         lat_exp = WAIT_CYCLES + 3; re_exp = 1; we_exp = 0; last_dout = shadow[a];
      end else begin
         lat_exp = WAIT_CYCLES + 2; re_exp = 0; we_exp = 1; shadow[a] = wd;
      end
      exp_q.push_back(last_dout);

      bus.mar_q = addr; bus.mdr_q = wd; bus.mem_read = rd; bus.mem_write = wr;
      lat = -1; re_n = 0; we_n = 0; pulse_k = -1; pulse_addr = '0; pulse_wd = '0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (bus.ram_re || bus.ram_we) begin
            pulse_k = k; pulse_addr = bus.ram_addr; pulse_wd = bus.ram_wdata;
         end
         if (bus.ram_re) re_n++;
         if (bus.ram_we) we_n++;
         if (k == 1 && !err_exp) check({tag, " busy"}, 64'(bus.mem_busy), 64'd1);
         if (bus.mem_done) begin lat = k; break; end
         if (!hold && k == 0) begin
            @(negedge clk);
            bus.mem_read = 1'b0; bus.mem_write = 1'b0;
         end
      end

      check({tag, " latency"}, 64'(lat), 64'(lat_exp));
      check({tag, " err"}, 64'(bus.mem_err), 64'(err_exp));
      check({tag, " re_cnt"}, 64'(re_n), 64'(re_exp));
      check({tag, " we_cnt"}, 64'(we_n), 64'(we_exp));
      if (re_exp + we_exp != 0) begin
         check({tag, " pulse_edge"}, 64'(pulse_k), 64'(WAIT_CYCLES + 1));
         check({tag, " pulse_addr"}, 64'(pulse_addr), 64'(a));
      end
      if (we_exp != 0) check({tag, " wdata"}, 64'(pulse_wd), 64'(wd));
      check({tag, " dout"}, 64'(bus.mem_data_out), 64'(exp_q.pop_front()));

      if (hold) begin
         extra = 0;
         repeat (2) begin
            @(posedge clk); #1;
            if (bus.ram_re || bus.ram_we) extra++;
         end
         check({tag, " done_held"}, 64'(bus.mem_done), 64'd1);
         check({tag, " no_reaccept"}, 64'(extra), 64'd0);
         @(negedge clk);
         bus.mem_read = 1'b0; bus.mem_write = 1'b0;
      end
      @(posedge clk); #1;
      check({tag, " done_fall"}, 64'(bus.mem_done), 64'd0);
      check({tag, " err_keep"}, 64'(bus.mem_err), 64'(err_exp));
      @(negedge clk);
   endtask

   initial begin
      int we_seen;
      bd_we = 1'b0; bd_addr = '0; bd_data = '0; last_dout = '0;
      bus.mem_read = 1'b1; bus.mem_write = 1'b0; bus.mar_q = 32'd5; bus.mdr_q = '0;
      bus.ram_rdata = '0;

      // Held in reset with a read pending: nothing may move
      preload(5, 32'hDEADBEEF);
      preload(0, 32'hA5A50000);
      preload(16, 32'h00001111);
      preload(32'h1F0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("reset data", {bus.mem_data_out, bus.ram_wdata}, 64'd0);
         check("reset ctrl", 64'({bus.mem_done, bus.mem_busy, bus.mem_err,
                                  bus.ram_re, bus.ram_we, bus.ram_addr}), 64'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      access("rd5", 1'b1, 1'b0, 32'd5, '0, 1'b1);

      access("wr1f0", 1'b0, 1'b1, 32'h1F0, 32'h12345678, 1'b1);
      access("rd1f0", 1'b1, 1'b0, 32'h1F0, '0, 1'b1);
      access("conflict", 1'b1, 1'b1, 32'h10, 32'h55, 1'b1);
      access("rd16_drop", 1'b1, 1'b0, 32'd16, '0, 1'b0);

      access("rd200", 1'b1, 1'b0, 32'h200, '0, 1'b1);
      access("wr205", 1'b0, 1'b1, 32'h205, 32'hCAFEF00D, 1'b1);
      access("rd5b", 1'b1, 1'b0, 32'd5, '0, 1'b1);

      // Reset during the WAIT phase of a write
      bus.mar_q = 32'd16; bus.mdr_q = 32'hBAD0BAD0; bus.mem_write = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("midrst busy", 64'(bus.mem_busy), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst ctrl", 64'({bus.mem_done, bus.mem_busy, bus.mem_err,
                                bus.ram_re, bus.ram_we, bus.ram_addr}), 64'd0);
      check("midrst data", {bus.mem_data_out, bus.ram_wdata}, 64'd0);
      bus.mem_write = 1'b0;
      last_dout = '0;
      we_seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (bus.ram_we) we_seen++;
      end
      check("midrst no_we", 64'(we_seen), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst ram", 64'(ram[16]), 64'h1111);
      access("rd16_post", 1'b1, 1'b0, 32'd16, '0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
